// File: rtl/bounce_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bounce_gen : regenerates a clean level as a bouncy switch (LFSR bursts)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bounce_gen #(
  parameter int unsigned N    = 4,
  parameter int unsigned K    = 3,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [K:0]   ONE_K = (K + 1)'(1);

  state_t       state;
  logic         level;
  logic         target;
  logic [7:0]   lfsr;
  logic [K:0]   rem;
  logic [N-1:0] icnt;
  logic [N-1:0] hcnt;
  logic [N-1:0] ival;
  logic [K-1:0] m;

  // A zero interval would stall the burst, so it is promoted to one cycle.
  always_comb begin
    ival = lfsr[N-1:0];
    if (ival == '0) ival = ONE_N;
  end

  assign m    = lfsr[7:8-K];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      level  <= 1'b0;
      target <= 1'b0;
      out    <= 1'b0;
      done   <= 1'b0;
      lfsr   <= SEED;
      rem    <= '0;
      icnt   <= '0;
      hcnt   <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      done <= 1'b0;
      case (state)
        IDLE: begin
          out <= level;
          if (in != level) begin
            target <= in;
            out    <= in;
            rem    <= {m, 1'b0};
            icnt   <= ival;
            state  <= BOUNCE;
          end
        end
        BOUNCE: begin
          // rem is always even, so out lands on target once it drains.
          if (rem == '0) begin
            hcnt  <= '1;
            state <= SETTLE;
          end else if (icnt == ONE_N) begin
            out  <= ~out;
            rem  <= rem - ONE_K;
            icnt <= ival;
          end else begin
            icnt <= icnt - ONE_N;
          end
        end
        SETTLE: begin
          out <= target;
          if (hcnt == '0) begin
            level <= target;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            hcnt <= hcnt - ONE_N;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bounce_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bounce_gen : randomized bench for bounce_gen against a burst model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bounce_gen;

  localparam int         N    = 2;
  localparam int         K    = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic in    = 1'b0;
  logic out;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int done_cnt = 0;
  logic prev_out = 1'b0;

  bounce_gen #(.N(N), .K(K), .SEED(SEED)) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Reference: whole burst planned as a list of toggle edges at detection.
  logic [7:0] m_lfsr;
  logic       m_busy, m_level, m_target;
  int         k, done_edge;
  int         tq[$];
  logic       exp_out, exp_busy, exp_done;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic toggle_parity(input int edge_idx);
    int c = 0;
    foreach (tq[i]) if (tq[i] <= edge_idx) c++;
    return c[0];
  endfunction

  task automatic plan_burst(input logic tgt);
    logic [7:0] s;
    int e, pairs, iv;
    pairs    = int'(m_lfsr[7:8-K]);
    m_target = tgt;
    m_busy   = 1'b1;
    k        = 0;
    tq.delete();
    e = 0;
    s = m_lfsr;
    for (int j = 0; j < 2 * pairs; j++) begin
      iv = int'(s[N-1:0]);
      if (iv == 0) iv = 1;
      for (int x = 0; x < iv; x++) s = lfsr_step(s);
      e += iv;
      tq.push_back(e);
    end
    done_edge = e + 1 + (1 << N);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr   = SEED;
      m_busy   = 1'b0;
      m_level  = 1'b0;
      m_target = 1'b0;
      exp_out  = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (!m_busy) begin
        exp_out = m_level;
        if (in != m_level) plan_burst(in);
      end else begin
        k++;
      end
      if (m_busy) begin
        if (k == done_edge) begin
          m_busy   = 1'b0;
          m_level  = m_target;
          exp_done = 1'b1;
          exp_out  = m_target;
        end else begin
          exp_out = m_target ^ toggle_parity(k);
        end
      end
      exp_busy = m_busy;
      m_lfsr   = lfsr_step(m_lfsr);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_val("out", 32'(out), 32'(exp_out));
    check_val("busy", 32'(busy), 32'(exp_busy));
    check_val("done", 32'(done), 32'(exp_done));
    if (done) done_cnt++;
    if (out != prev_out) edge_cnt++;
    prev_out = out;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      seen = done;
    end
    check_val("done_seen", 32'(seen), 32'd1);
  endtask

  logic [39:0] vec_a, vec_b;
  int hold;

  initial begin
    // Reset held with in high: everything stays at zero.
    reset = 1'b1;
    in    = 1'b1;
    repeat (3) tick();
    check_val("rst_out", 32'(out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);

    // Single change: first edge immediately after release, then a burst.
    reset    = 1'b0;
    edge_cnt = 0;
    done_cnt = 0;
    prev_out = out;
    tick();
    check_val("first_edge", 32'(out), 32'd1);
    check_val("first_busy", 32'(busy), 32'd1);
    wait_done(100);
    check_val("busy_with_done", 32'(busy), 32'd0);
    check_val("edge_odd", 32'(edge_cnt % 2), 32'd1);
    check_val("edge_le15", 32'(edge_cnt <= 15), 32'd1);
    repeat (6) tick();
    check_val("one_done", 32'(done_cnt), 32'd1);
    check_val("final_out", 32'(out), 32'd1);

    // Glitch on in during a burst is ignored; net-unchanged in starts nothing.
    in = 1'b0;
    tick();
    done_cnt = 0;
    in = 1'b1;
    tick();
    in = 1'b0;
    tick();
    wait_done(100);
    repeat (8) tick();
    check_val("ignore_dones", 32'(done_cnt), 32'd1);
    check_val("ignore_out", 32'(out), 32'd0);
    check_val("ignore_idle", 32'(busy), 32'd0);

    // Back-to-back: in flips back while busy, next burst follows done.
    done_cnt = 0;
    in = 1'b1;
    tick();
    tick();
    in = 1'b0;
    wait_done(100);
    tick();
    check_val("b2b_restart", 32'(busy), 32'd1);
    wait_done(100);
    repeat (4) tick();
    check_val("b2b_out", 32'(out), 32'd0);
    check_val("b2b_dones", 32'(done_cnt), 32'd2);

    // Reset two cycles into BOUNCE, then the pattern must replay identically.
    reset = 1'b1;
    in    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    in    = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_val("midrst_out", 32'(out), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vec_a[i] = out;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vec_b[i] = out;
    end
    check_val("replay_lo", vec_b[31:0], vec_a[31:0]);
    check_val("replay_hi", 32'(vec_b[39:32]), 32'(vec_a[39:32]));

    // Random level steps with occasional resets.
    for (int s = 0; s < 20; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      in   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 70);
      repeat (hold) tick();
    end
    repeat (120) tick();
    check_val("rand_settled", 32'(out), 32'(in));
    check_val("rand_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
